cache_ctrl_param: RTL
=====================

CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
- REQ-001 Parameter WORDS_PER_BLOCK, default 4: words per cache block; power of two, >=1.
- REQ-002 Parameter WORD_BYTES, default 4: bytes per word; power of two, >=1.
- REQ-003 Derived constant WSEL_W = max(1, clog2(WORDS_PER_BLOCK)): width of word index signals.
- REQ-004 clk  in  1  single clock; all state updates on rising edge.
- REQ-005 rst  in  1  reset; asynchronous, active-high.
- REQ-006 Req_CPU  in  1  CPU access request; held until Rdy_CPU.
- REQ-007 Wr_CPU  in  1  1 = write access, 0 = read access.
- REQ-008 Byte_En_CPU  in  WORD_BYTES  byte lanes written by a CPU write.
- REQ-009 Word_Select  in  WSEL_W  target word within the block.
- REQ-010 Hit, Dirty  in  1 each  tag-compare hit; dirty bit of the indexed line.
- REQ-011 Rdy_Low  in  1  memory beat complete this cycle.
- REQ-012 Rdy_CPU  out  1  CPU access done this cycle.
- REQ-013 Req_Low, Wr_Low  out  1 each  memory request; memory write.
- REQ-014 Burst_Cnt  out  WSEL_W  word index of the current memory beat.
- REQ-015 En_Word  out  WORDS_PER_BLOCK  one-hot-or-zero data-array word enable.
- REQ-016 En_Byte  out  WORD_BYTES  data-array byte enable.
- REQ-017 Wn  out  WORDS_PER_BLOCK  per-word data mux select; 1 = memory data, 0 = CPU data.
- REQ-018 Wr, ValidNew, DirtyNew  out  1 each  array write strobe; new valid bit; new dirty bit.
- REQ-019 ASel  out  1  1 = memory address from {stored tag, index}; 0 = CPU address.

Function
- REQ-020 States: INIT, TAG, WB, MB, WT. All outputs are decoded combinationally from state, inputs and Burst_Cnt.
- REQ-021 INIT SHALL go to TAG on the next edge; all outputs 0.
- REQ-022 In TAG with Req_CPU&Hit: Rdy_CPU=1 in the same cycle; the block stays in TAG.
- REQ-023 TAG write hit: Wr=1, En_Word=onehot(Word_Select), En_Byte=Byte_En_CPU, Wn=0, ValidNew=1, DirtyNew=1.
- REQ-024 TAG read hit: Wr=0, En_Word=0.
- REQ-025 TAG with Req_CPU&~Hit: go to WB if Dirty, else MB (WT case per REQ-038). Hit and Dirty are sampled only in TAG.
- REQ-026 TAG with Req_CPU=0: all outputs 0; the block stays in TAG.
- REQ-027 WB: Req_Low=1, Wr_Low=1, ASel=1, Wr=0; each cycle with Rdy_Low=1 is one beat and increments Burst_Cnt.
- REQ-028 WB last beat (Burst_Cnt==WORDS_PER_BLOCK-1 and Rdy_Low): Burst_Cnt->0; go to MB.
- REQ-029 MB: Req_Low=1, Wr_Low=0, ASel=0, Wn=all ones. On each beat: Wr=1, En_Word=onehot(Burst_Cnt), En_Byte=all ones, ValidNew=1, DirtyNew=0.
- REQ-030 MB last beat: Burst_Cnt->0; go to TAG. Rdy_CPU stays 0 in MB. The held request is serviced in TAG as a hit; writes merge there.
- REQ-031 Bursts are never aborted. A Req_CPU drop mid-WB/MB does not change the sequence.
- REQ-032 WORDS_PER_BLOCK=1: every beat is the last beat; Burst_Cnt stays 0.
- REQ-033 Unreachable state encodings SHALL go to INIT on the next edge.

Reset
- REQ-034 rst=1 forces state=INIT and Burst_Cnt=0 immediately, including mid-burst.
- REQ-035 During reset all outputs are 0: Rdy_CPU, Req_Low, Wr_Low, Wr, ValidNew, DirtyNew, ASel=0; En_Word, En_Byte, Wn=0.
- REQ-036 After rst deasserts, the first edge enters INIT->TAG per REQ-021.

Configuration
- REQ-037 Macro CACHE_CTRL_WRITE_ALLOCATE_EN defined: write misses follow REQ-025 (allocate); state WT is not built.
- REQ-038 Macro undefined: a clean write miss (Req_CPU&Wr_CPU&~Hit&~Dirty) goes to WT. In WT: Req_Low=1, Wr_Low=1, ASel=0, Wr=0. On Rdy_Low: Rdy_CPU=1, go to TAG. A dirty write miss still follows WB->MB.

Verification
- REQ-039 WPB=4, TAG read hit Word_Select=2 -> Rdy_CPU=1 same cycle, Wr=0, no state change.
- REQ-040 Write hit Word_Select=1, Byte_En_CPU=0011 -> En_Word=0010, En_Byte=0011, Wn=0000, DirtyNew=1, Rdy_CPU=1.
- REQ-041 Dirty read miss, Rdy_Low every 2nd cycle -> 4 WB beats (ASel=1, Burst_Cnt 0..3), then 4 MB beats (En_Word 0001..1000), then TAG, then Rdy_CPU.
- REQ-042 rst pulsed during MB beat 2 -> outputs 0 immediately, Burst_Cnt=0, INIT then TAG.
- REQ-043 Macro undefined, clean write miss -> WT, Wr_Low=1, Rdy_CPU=1 on the Rdy_Low cycle, no array write; macro defined -> MB refill, then write hit.

Source files
------------

// File: rtl/cache_ctrl_param.sv
// Blocking write-back cache controller: tag check, write-back and refill bursts.
// CACHE_CTRL_WRITE_ALLOCATE_EN selects write-allocate; otherwise clean write misses write through.
module cache_ctrl_param #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WORD_BYTES      = 4,
  localparam int WSEL_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Req_CPU,
  input  logic                       Wr_CPU,
  input  logic [WORD_BYTES-1:0]      Byte_En_CPU,
  input  logic [WSEL_W-1:0]          Word_Select,
  input  logic                       Hit,
  input  logic                       Dirty,
  input  logic                       Rdy_Low,
  output logic                       Rdy_CPU,
  output logic                       Req_Low,
  output logic                       Wr_Low,
  output logic [WSEL_W-1:0]          Burst_Cnt,
  output logic [WORDS_PER_BLOCK-1:0] En_Word,
  output logic [WORD_BYTES-1:0]      En_Byte,
  output logic [WORDS_PER_BLOCK-1:0] Wn,
  output logic                       Wr,
  output logic                       ValidNew,
  output logic                       DirtyNew,
  output logic                       ASel
);

`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_TAG  = 3'd1,
    S_WB   = 3'd2,
    S_MB   = 3'd3
  } state_t;
`else
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_TAG  = 3'd1,
    S_WB   = 3'd2,
    S_MB   = 3'd3,
    S_WT   = 3'd4
  } state_t;
`endif

  localparam logic [WSEL_W-1:0] LAST =
    WSEL_W'(WORDS_PER_BLOCK - 1);

  state_t            state_q, state_d;
  logic [WSEL_W-1:0] bcnt_q, bcnt_d;
  logic              last;

  function automatic logic [WORDS_PER_BLOCK-1:0] onehot(
    input logic [WSEL_W-1:0] idx
  );
    return WORDS_PER_BLOCK'(1) << idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign Burst_Cnt = bcnt_q;
  assign last      = (bcnt_q == LAST);

  always_comb begin
    state_d  = S_INIT;
    bcnt_d   = bcnt_q;
    Rdy_CPU  = 1'b0;
    Req_Low  = 1'b0;
    Wr_Low   = 1'b0;
    En_Word  = '0;
    En_Byte  = '0;
    Wn       = '0;
    Wr       = 1'b0;
    ValidNew = 1'b0;
    DirtyNew = 1'b0;
    ASel     = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_TAG;
      S_TAG: begin
        state_d = S_TAG;
        if (Req_CPU) begin
          if (Hit) begin
            Rdy_CPU = 1'b1;
            if (Wr_CPU) begin
              Wr       = 1'b1;
              En_Word  = onehot(Word_Select);
              En_Byte  = Byte_En_CPU;
              ValidNew = 1'b1;
              DirtyNew = 1'b1;
            end
          end else if (Dirty) begin
            state_d = S_WB;
`ifndef CACHE_CTRL_WRITE_ALLOCATE_EN
          end else if (Wr_CPU) begin
            state_d = S_WT;
`endif
          end else begin
            state_d = S_MB;
          end
        end
      end
      S_WB: begin
        state_d = S_WB;
        Req_Low = 1'b1;
        Wr_Low  = 1'b1;
        ASel    = 1'b1;
        if (Rdy_Low) begin
          if (last) begin
            bcnt_d  = '0;
            state_d = S_MB;
          end else begin
            bcnt_d = bcnt_q + WSEL_W'(1);
          end
        end
      end
      S_MB: begin
        state_d = S_MB;
        Req_Low = 1'b1;
        Wn      = '1;
        // refill beat lands straight into the data array
        if (Rdy_Low) begin
          Wr       = 1'b1;
          En_Word  = onehot(bcnt_q);
          En_Byte  = '1;
          ValidNew = 1'b1;
          if (last) begin
            bcnt_d  = '0;
            state_d = S_TAG;
          end else begin
            bcnt_d = bcnt_q + WSEL_W'(1);
          end
        end
      end
`ifndef CACHE_CTRL_WRITE_ALLOCATE_EN
      S_WT: begin
        state_d = S_WT;
        Req_Low = 1'b1;
        Wr_Low  = 1'b1;
        if (Rdy_Low) begin
          Rdy_CPU = 1'b1;
          state_d = S_TAG;
        end
      end
`endif
      default: state_d = S_INIT;
    endcase
  end

endmodule
